// File: rtl/spi_page_program.sv
// M25P16 page-program controller: WREN, then PP with a 24-bit address and 1..256 data bytes,
// then RDSR polling until WIP clears. SPI mode 0, MSB first.
module spi_page_program #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 5
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [8:0]  len,
  output logic        wr_req,
  input  logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_cs,
  output logic        spi_mosi
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

  localparam logic [7:0] OpWren = 8'h06;
  localparam logic [7:0] OpPp   = 8'h02;
  localparam logic [7:0] OpRdsr = 8'h05;

  typedef enum logic [3:0] {
    StIdle,
    StWren,
    StGap1,
    StPpCmd,
    StPpAddr,
    StPpData,
    StGap2,
    StRdsrCmd,
    StRdsrPoll,
    StFin
  } state_e;

  state_e          state_q;
  state_e          byte_next_state;
  logic [DivW-1:0] div_q;
  logic [GapW-1:0] gap_q;
  logic [2:0]      bit_q;
  logic [7:0]      tx_q;
  logic            miso_q;
  logic [8:0]      byte_cnt_q;
  logic [23:0]     addr_q;
  logic [1:0]      addr_idx_q;
  logic            tail_q;
  logic            req_dly_q;
  logic [7:0]      data_q;

  logic            div_end;
  logic [8:0]      cnt_dec;
  logic [7:0]      load_byte;
  logic            frame_last;
  logic            req_next;

  assign div_end = (div_q == DivLast);
  assign cnt_dec = byte_cnt_q - 9'd1;

  // What happens at the end of the byte currently on the wire: the next byte to shift,
  // whether the frame closes instead, and whether to fetch another data byte.
  always_comb begin
    load_byte       = 8'h00;
    frame_last      = 1'b0;
    req_next        = 1'b0;
    byte_next_state = state_q;
    case (state_q)
      StWren: frame_last = 1'b1;
      StPpCmd: begin
        load_byte       = addr_q[23:16];
        byte_next_state = StPpAddr;
      end
      StPpAddr: begin
        case (addr_idx_q)
          2'd0: load_byte = addr_q[15:8];
          2'd1: begin
            load_byte = addr_q[7:0];
            req_next  = 1'b1;
          end
          default: begin
            load_byte       = data_q;
            req_next        = (byte_cnt_q > 9'd1);
            byte_next_state = StPpData;
          end
        endcase
      end
      StPpData: begin
        frame_last = (cnt_dec == 9'd0);
        load_byte  = data_q;
        req_next   = (cnt_dec > 9'd1);
      end
      StRdsrCmd: byte_next_state = StRdsrPoll;
      StRdsrPoll: frame_last = !miso_q;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      gap_q      <= '0;
      bit_q      <= 3'd0;
      tx_q       <= 8'h00;
      miso_q     <= 1'b0;
      byte_cnt_q <= 9'd0;
      addr_q     <= 24'h000000;
      addr_idx_q <= 2'd0;
      tail_q     <= 1'b0;
      req_dly_q  <= 1'b0;
      data_q     <= 8'h00;
      wr_req     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      spi_sclk   <= 1'b0;
      spi_cs     <= 1'b1;
      spi_mosi   <= 1'b0;
    end else begin
      wr_req    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      // The source presents wr_data one cycle after wr_req.
      req_dly_q <= wr_req;
      if (req_dly_q) data_q <= wr_data;

      case (state_q)
        StIdle: begin
          if (start) begin
            if (len == 9'd0 || len > 9'd256) begin
              err <= 1'b1;
            end else begin
              addr_q     <= addr;
              byte_cnt_q <= len;
              busy       <= 1'b1;
              spi_cs     <= 1'b0;
              spi_mosi   <= OpWren[7];
              tx_q       <= {OpWren[6:0], 1'b0};
              bit_q      <= 3'd7;
              div_q      <= '0;
              tail_q     <= 1'b0;
              state_q    <= StWren;
            end
          end
        end

        StGap1, StGap2: begin
          if (gap_q == GapLast) begin
            spi_cs <= 1'b0;
            bit_q  <= 3'd7;
            div_q  <= '0;
            tail_q <= 1'b0;
            if (state_q == StGap1) begin
              spi_mosi <= OpPp[7];
              tx_q     <= {OpPp[6:0], 1'b0};
              state_q  <= StPpCmd;
            end else begin
              spi_mosi <= OpRdsr[7];
              tx_q     <= {OpRdsr[6:0], 1'b0};
              state_q  <= StRdsrCmd;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        StFin: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          if (!div_end) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (tail_q) begin
              // Half a bit after the last falling edge: release CS.
              spi_cs <= 1'b1;
              tail_q <= 1'b0;
              gap_q  <= '0;
              if (state_q == StWren) begin
                state_q <= StGap1;
              end else if (state_q == StPpData) begin
                state_q <= StGap2;
              end else begin
                state_q <= StFin;
              end
            end else if (!spi_sclk) begin
              spi_sclk <= 1'b1;
              miso_q   <= spi_miso;
            end else begin
              spi_sclk <= 1'b0;
              if (bit_q != 3'd0) begin
                spi_mosi <= tx_q[7];
                tx_q     <= {tx_q[6:0], 1'b0};
                bit_q    <= bit_q - 3'd1;
              end else begin
                if (state_q == StPpData) byte_cnt_q <= cnt_dec;
                if (frame_last) begin
                  tail_q   <= 1'b1;
                  spi_mosi <= 1'b0;
                end else begin
                  spi_mosi   <= load_byte[7];
                  tx_q       <= {load_byte[6:0], 1'b0};
                  bit_q      <= 3'd7;
                  wr_req     <= req_next;
                  addr_idx_q <= (state_q == StPpAddr) ? addr_idx_q + 2'd1 : 2'd0;
                  state_q    <= byte_next_state;
                end
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_page_program.sv
// Directed bench for spi_page_program with a small behavioural M25P16 model and byte source.
`timescale 1ns/1ps
module tb_spi_page_program;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [23:0] addr;
  logic [8:0]  len;
  logic        wr_req;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        spi_miso;
  logic        spi_sclk;
  logic        spi_cs;
  logic        spi_mosi;

  spi_page_program #(.CLK_DIV(2), .CS_GAP(5)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .addr     (addr),
    .len      (len),
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .spi_miso (spi_miso),
    .spi_sclk (spi_sclk),
    .spi_cs   (spi_cs),
    .spi_mosi (spi_mosi)
  );

  always #10 sys_clk = ~sys_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- flash model ----------------
  logic [7:0]  mem [int];
  logic [7:0]  log_b [$];
  int          fr_start [$];
  int          fr_len [$];
  logic        m_cs_prev   = 1'b1;
  logic        m_in_frame  = 1'b0;
  logic        m_wel       = 1'b0;
  logic        m_cs_seen   = 1'b0;
  logic        m_rise_ok   = 1'b0;
  int          m_bitpos    = 0;
  int          m_nbytes    = 0;
  logic [7:0]  m_sh        = 8'h00;
  logic [7:0]  m_cmd       = 8'h00;
  time         m_last_rise = 0;
  time         m_cs_rise_t = 0;
  time         per_min     = 64'd1000000;
  time         per_max     = 0;
  time         gap_min     = 64'd1000000;
  int          wip_reads   = 1;
  int          m_s;
  int          m_a;
  logic [23:0] m_pa;
  logic [7:0]  m_lo;

  function automatic logic [7:0] rd(input int a);
    return mem.exists(a) ? mem[a] : 8'hFF;
  endfunction

  // Status byte is 0x01 (WIP) for the first wip_reads reads of a frame, then 0x00.
  assign spi_miso = (m_cmd == 8'h05) && (m_nbytes >= 1) && (m_bitpos == 7) &&
                    ((m_nbytes - 1) < wip_reads);

  always @(posedge spi_sclk or posedge spi_cs or negedge spi_cs) begin
    if (spi_cs !== m_cs_prev) begin
      m_cs_prev = spi_cs;
      if (spi_cs == 1'b0) begin
        if (m_cs_seen && (($time - m_cs_rise_t) < gap_min)) gap_min = $time - m_cs_rise_t;
        m_in_frame = 1'b1;
        m_bitpos   = 0;
        m_nbytes   = 0;
        m_cmd      = 8'h00;
        m_rise_ok  = 1'b0;
        fr_start.push_back(log_b.size());
      end else begin
        m_cs_rise_t = $time;
        m_cs_seen   = 1'b1;
        if (m_in_frame) begin
          fr_len.push_back(m_nbytes);
          if (m_bitpos == 0) begin
            if (m_cmd == 8'h06 && m_nbytes == 1) begin
              m_wel = 1'b1;
            end else if (m_cmd == 8'h02 && m_wel && m_nbytes >= 5) begin
              m_s  = fr_start[fr_start.size() - 1];
              m_pa = {log_b[m_s + 1], log_b[m_s + 2], log_b[m_s + 3]};
              for (int i = 4; i < m_nbytes; i++) begin
                m_lo = m_pa[7:0] + 8'(i - 4);
                m_a  = int'({m_pa[23:8], m_lo});
                mem[m_a] = rd(m_a) & log_b[m_s + i];
              end
              m_wel = 1'b0;
            end
          end
        end
        m_in_frame = 1'b0;
      end
    end else if (spi_cs == 1'b0 && m_in_frame) begin
      if (m_rise_ok) begin
        if (($time - m_last_rise) < per_min) per_min = $time - m_last_rise;
        if (($time - m_last_rise) > per_max) per_max = $time - m_last_rise;
      end
      m_last_rise = $time;
      m_rise_ok   = 1'b1;
      m_sh        = {m_sh[6:0], spi_mosi};
      if (m_bitpos == 7) begin
        log_b.push_back(m_sh);
        if (m_nbytes == 0) m_cmd = m_sh;
        m_nbytes++;
        m_bitpos = 0;
      end else begin
        m_bitpos++;
      end
    end
  end

  // ---------------- byte source and monitor ----------------
  logic [7:0] src [256];
  int   req_base      = 0;
  int   req_cnt       = 0;
  int   done_cnt      = 0;
  int   err_cnt       = 0;
  int   both_cnt      = 0;
  int   done_busy_bad = 0;
  int   cs_low_cyc    = 0;
  int   busy_cyc      = 0;
  logic req_prev      = 1'b0;
  logic busy_prev     = 1'b0;

  // wr_data is valid only in the cycle after wr_req; otherwise it carries the complement.
  always @(negedge sys_clk) begin
    if (req_prev) wr_data = src[(req_cnt - 1 - req_base) & 255];
    else          wr_data = ~src[(req_cnt - req_base) & 255];
    if (wr_req) req_cnt++;
    req_prev = wr_req;
    if (done) begin
      done_cnt++;
      if (busy !== 1'b0 || busy_prev !== 1'b1) done_busy_bad++;
    end
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if (!spi_cs) cs_low_cyc++;
    if (busy) busy_cyc++;
    busy_prev = busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int          f0;
  int          d0;
  int          e0;
  int          c0;
  int          b0;
  int          bad;
  int          n;
  logic [63:0] v;

  task automatic do_start(input logic [23:0] a, input logic [8:0] l);
    @(negedge sys_clk);
    addr  = a;
    len   = l;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string tag);
    int k = 0;
    while (done_cnt == base && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    check(tag, 64'(done_cnt > base), 64'd1);
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic wait_req(input int target, input int budget, input string tag);
    int k = 0;
    while ((req_cnt - req_base) < target && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    check(tag, 64'((req_cnt - req_base) >= target), 64'd1);
  endtask

  task automatic begin_op();
    req_base = req_cnt;
    f0 = fr_start.size();
    d0 = done_cnt;
  endtask

  initial begin
    sys_rst = 1'b1;
    start   = 1'b0;
    addr    = 24'h0;
    len     = 9'd0;
    for (int i = 0; i < 256; i++) src[i] = 8'h00;
    #25;
    check("rst_cs", 64'(spi_cs), 64'd1);
    check("rst_sclk", 64'(spi_sclk), 64'd0);
    check("rst_mosi", 64'(spi_mosi), 64'd0);
    check("rst_outs", 64'({wr_req, busy, done, err}), 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    // 4 bytes at 0x000000, one WIP read.
    src[0] = 8'hAA; src[1] = 8'h55; src[2] = 8'h01; src[3] = 8'h02;
    wip_reads = 1;
    begin_op();
    do_start(24'h000000, 9'd4);
    wait_done(d0, 3000, "t1_done");
    check("t1_frames", 64'(fr_start.size() - f0), 64'd3);
    check("t1_wren", 64'({log_b[fr_start[f0]], 8'(fr_len[f0])}), 64'h0601);
    check("t1_pp_len", 64'(fr_len[f0 + 1]), 64'd8);
    v = 64'h0;
    for (int i = 0; i < 8; i++) v = {v[55:0], log_b[fr_start[f0 + 1] + i]};
    check("t1_pp_bytes", v, 64'h02000000AA550102);
    check("t1_rdsr_cmd", 64'(log_b[fr_start[f0 + 2]]), 64'h05);
    check("t1_rdsr_len", 64'(fr_len[f0 + 2]), 64'd3);
    check("t1_done_once", 64'(done_cnt - d0), 64'd1);
    check("t1_busy_fall", 64'(done_busy_bad), 64'd0);
    check("t1_wr_req", 64'(req_cnt - req_base), 64'd4);
    check("t1_mem", 64'({rd(0), rd(1), rd(2), rd(3), rd(4)}), 64'hAA550102FF);
    check("t1_sclk_min", 64'(per_min), 64'd80);
    check("t1_sclk_max", 64'(per_max), 64'd80);
    check("t1_cs_gap", 64'(gap_min >= 100), 64'd1);

    // Full page at 0x010000.
    for (int i = 0; i < 256; i++) src[i] = 8'(i);
    wip_reads = 2;
    begin_op();
    do_start(24'h010000, 9'd256);
    wait_done(d0, 12000, "t2_done");
    check("t2_wr_req", 64'(req_cnt - req_base), 64'd256);
    check("t2_pp_len", 64'(fr_len[f0 + 1]), 64'd260);
    bad = 0;
    for (int i = 0; i < 256; i++) if (rd(32'h010000 + i) !== 8'(i)) bad++;
    check("t2_mem_bad", 64'(bad), 64'd0);
    check("t2_next_page", 64'(rd(32'h010100)), 64'hFF);
    check("t2_rdsr_len", 64'(fr_len[f0 + 2]), 64'd4);

    // Rejected lengths.
    e0 = err_cnt; c0 = cs_low_cyc; b0 = busy_cyc; f0 = fr_start.size();
    do_start(24'h000000, 9'd0);
    repeat (20) @(negedge sys_clk);
    check("t3_len0_err", 64'(err_cnt - e0), 64'd1);
    check("t3_len0_busy", 64'(busy_cyc - b0), 64'd0);
    check("t3_len0_cs", 64'(cs_low_cyc - c0), 64'd0);
    e0 = err_cnt; c0 = cs_low_cyc; b0 = busy_cyc;
    do_start(24'h000000, 9'd300);
    repeat (20) @(negedge sys_clk);
    check("t3_len300_err", 64'(err_cnt - e0), 64'd1);
    check("t3_len300_busy", 64'(busy_cyc - b0), 64'd0);
    check("t3_len300_cs", 64'(cs_low_cyc - c0), 64'd0);
    check("t3_no_frames", 64'(fr_start.size() - f0), 64'd0);

    // Start during PP_DATA must be ignored.
    for (int i = 0; i < 8; i++) src[i] = 8'(8'h11 * (i + 1));
    wip_reads = 1;
    begin_op();
    e0 = err_cnt;
    do_start(24'h000200, 9'd8);
    wait_req(3, 2000, "t4_reach_data");
    check("t4_busy", 64'(busy), 64'd1);
    do_start(24'h000000, 9'd3);
    wait_done(d0, 4000, "t4_done");
    repeat (60) @(negedge sys_clk);
    check("t4_wr_req", 64'(req_cnt - req_base), 64'd8);
    check("t4_pp_len", 64'(fr_len[f0 + 1]), 64'd12);
    v = 64'h0;
    for (int i = 0; i < 8; i++) v = {v[55:0], rd(32'h000200 + i)};
    check("t4_mem", v, 64'h1122334455667788);
    check("t4_frames", 64'(fr_start.size() - f0), 64'd3);
    check("t4_done_once", 64'(done_cnt - d0), 64'd1);
    check("t4_no_err", 64'(err_cnt - e0), 64'd0);

    // Asynchronous reset during data byte 2, then a clean operation.
    for (int i = 0; i < 4; i++) src[i] = 8'(8'h40 + i);
    begin_op();
    do_start(24'h000300, 9'd4);
    wait_req(3, 2000, "t5_reach_byte2");
    repeat (5) @(negedge sys_clk);
    check("t5_cs_low", 64'(spi_cs), 64'd0);
    #3 sys_rst = 1'b1;
    #1;
    check("t5_rst_outs", 64'({spi_cs, spi_sclk, busy}), 64'h4);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (10) @(negedge sys_clk);
    check("t5_aborted", 64'(rd(32'h000300)), 64'hFF);
    src[0] = 8'hC3; src[1] = 8'h3C;
    begin_op();
    do_start(24'h000400, 9'd2);
    wait_done(d0, 3000, "t5_done");
    check("t5_wr_req", 64'(req_cnt - req_base), 64'd2);
    check("t5_mem", 64'({rd(32'h000400), rd(32'h000401)}), 64'hC33C);

    // Three WIP reads in one RDSR frame, single-byte program.
    src[0] = 8'h5A;
    wip_reads = 3;
    begin_op();
    do_start(24'h000500, 9'd1);
    wait_done(d0, 3000, "t6_done");
    check("t6_pp_len", 64'(fr_len[f0 + 1]), 64'd5);
    check("t6_rdsr_len", 64'(fr_len[f0 + 2]), 64'd5);
    check("t6_wr_req", 64'(req_cnt - req_base), 64'd1);
    check("t6_mem", 64'(rd(32'h000500)), 64'h5A);

    check("never_done_err", 64'(both_cnt), 64'd0);
    check("busy_fall_all", 64'(done_busy_bad), 64'd0);

    n = n_fail;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n);
    $finish;
  end

endmodule
